des_round_ctrl: RTL

- Iterative DES engine controller. Accepts one 64-bit block, one 64-bit key and a direction over a valid/ready handshake, then runs 16 Feistel rounds at one round per cycle.
- Owns the L/R half-block registers and the C/D key-schedule registers.
- Drives a single shared round-function datapath (expansion P-box, key XOR, S-boxes, P permutation) through dedicated ports, then returns the result over a valid/ready handshake.

---
 rtl/des_pkg.sv | 64 ++++++
 rtl/des_key_sched.sv | 67 ++++++
 rtl/des_round_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
// des_pkg : DES widths, controller state encodings, key shift schedule and
//           the IP / FP / PC1 / PC2 permutations (FIPS 46-3 bit numbering)
// Revision: 1.0
// ============================================================================
package des_pkg;

  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int SUBKEY_W = 48;
  localparam int CD_W     = 28;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] SHIFT [16] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

  // Table entry i names the source bit (1-based) for output bit i+1.
  localparam int IP_TAB [64] = '{58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
                                 62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
                                 57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
                                 61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_TAB [64] = '{40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
                                 38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
                                 36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
                                 34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int PC1_TAB [56] = '{57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
                                  10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
                                  63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
                                  14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_TAB [48] = '{14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
                                  23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
                                  41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                                  44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [1:64] ip(input logic [1:64] b);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[7'(i + 1)] = b[IP_TAB[6'(i)][6:0]];
    return o;
  endfunction

  function automatic logic [1:64] fp(input logic [1:64] b);
    logic [1:64] o;
    for (int i = 0; i < 64; i++) o[7'(i + 1)] = b[FP_TAB[6'(i)][6:0]];
    return o;
  endfunction

  function automatic logic [1:56] pc1(input logic [1:64] b);
    logic [1:56] o;
    for (int i = 0; i < 56; i++) o[6'(i + 1)] = b[PC1_TAB[6'(i)][6:0]];
    return o;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] b);
    logic [1:48] o;
    for (int i = 0; i < 48; i++) o[6'(i + 1)] = b[PC2_TAB[6'(i)][5:0]];
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched.sv
`default_nettype none
// ============================================================================
// des_key_sched : C/D key-schedule registers, direction-dependent rotation
//                 and PC2 subkey selection for the iterative DES controller
// Revision: 1.0
// ============================================================================
module des_key_sched
  import des_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic              decrypt,
  input  logic [3:0]        round,
  input  logic [1:BLOCK_W]  key,
  output logic [1:SUBKEY_W] subkey
);

  logic [1:CD_W] r_c;
  logic [1:CD_W] r_d;
  logic [1:CD_W] w_c_next;
  logic [1:CD_W] w_d_next;
  logic [1:0]    w_amt;
  logic          w_right;

  function automatic logic [1:CD_W] rot(input logic [1:CD_W] x, input logic [1:0] amt,
                                        input logic right);
    logic [1:CD_W] o;
    case ({right, amt})
      3'b001:  o = {x[2:CD_W], x[1]};
      3'b010:  o = {x[3:CD_W], x[1:2]};
      3'b101:  o = {x[CD_W], x[1:CD_W-1]};
      3'b110:  o = {x[CD_W-1:CD_W], x[1:CD_W-2]};
      default: o = x;
    endcase
    return o;
  endfunction

  // Decrypt walks the schedule backwards; SHIFT[16-k] is SHIFT[-k mod 16].
  always_comb begin
    w_right = 1'b0;
    w_amt   = SHIFT[round];
    if (decrypt) begin
      w_right = 1'b1;
      w_amt   = (round == 4'd0) ? 2'd0 : SHIFT[4'd0 - round];
    end
  end

  assign w_c_next = rot(r_c, w_amt, w_right);
  assign w_d_next = rot(r_d, w_amt, w_right);
  assign subkey   = pc2({w_c_next, w_d_next});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_c <= '0;
      r_d <= '0;
    end else if (load) begin
      {r_c, r_d} <= pc1(key);
    end else if (advance) begin
      r_c <= w_c_next;
      r_d <= w_d_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/des_round_ctrl.sv
`default_nettype none
// ============================================================================
// des_round_ctrl : iterative DES controller, one Feistel round per cycle,
//                  with an external round-function datapath on the f_* ports
// Revision: 1.0
// ============================================================================
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:BLOCK_W]  in_block,
  input  logic [1:BLOCK_W]  in_key,
  input  logic              in_decrypt,
  output logic [1:HALF_W]   f_r_o,
  output logic [1:SUBKEY_W] f_k_o,
  input  logic [1:HALF_W]   f_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:BLOCK_W]  out_block,
  output logic              busy_o,
  output logic [3:0]        round_o
);

  logic [1:0]       r_state;
  logic [3:0]       r_round;
  logic [1:HALF_W]  r_l;
  logic [1:HALF_W]  r_r;
  logic             r_decrypt;
  logic [1:BLOCK_W] r_out_block;
  logic [1:HALF_W]  w_r_next;
  logic             w_accept;
  logic             w_last;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy_o    = (r_state != IDLE);
  assign round_o   = r_round;
  assign out_block = r_out_block;
  assign f_r_o     = r_r;
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_round == 4'(NUM_ROUNDS - 1));
  assign w_r_next  = r_l ^ f_i;

  des_key_sched u_key_sched (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_accept),
    .advance (r_state == ROUND),
    .decrypt (r_decrypt),
    .round   (r_round),
    .key     (in_key),
    .subkey  (f_k_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_round     <= '0;
      r_l         <= '0;
      r_r         <= '0;
      r_decrypt   <= 1'b0;
      r_out_block <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            {r_l, r_r} <= ip(in_block);
            r_decrypt  <= in_decrypt;
            r_round    <= '0;
            r_state    <= ROUND;
          end
        end
        ROUND: begin
          r_l     <= r_r;
          r_r     <= w_r_next;
          r_round <= r_round + 4'd1;
          // Final round: halves are swapped ahead of the final permutation.
          if (w_last) begin
            r_out_block <= fp({w_r_next, r_r});
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
